// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Layer-level instruction sequencer for the core datapath.
//               Emits one 35-bit inst word per cycle. The stages are weight
//               stream, flush, activation stream, output drain, optional
//               accumulate and done.
// Options     : SEQ_ACC_PHASE_EN adds the ACC (psum read-back) phase.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer #(
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int ADDR_BW = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_BW-1:0] cfg_w_base,
   input  logic [ADDR_BW-1:0] cfg_x_base,
   input  logic [ADDR_BW-1:0] cfg_p_base,
   input  logic [ADDR_BW-1:0] cfg_n_x,
   input  logic               cfg_relu,
   input  logic               ofifo_valid,
   output logic [34:0]        inst,
   output logic               busy,
   output logic               done
);
   localparam int          CW          = ADDR_BW + 1;
   localparam logic [34:0] c_IDLE_INST = 35'h1_800C_0000;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WSTREAM = 3'd1,
      S_WFLUSH  = 3'd2,
      S_XSTREAM = 3'd3,
      S_DRAIN   = 3'd4,
      S_ACC     = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ADDR_BW-1:0] w_base_q, w_base_d, x_base_q, x_base_d;
   logic [ADDR_BW-1:0] p_base_q, p_base_d, n_x_q, n_x_d;
   logic [34:0]        inst_q, inst_d;
   logic               busy_q, done_q;
   logic [CW-1:0]      w_lim;
   logic [ADDR_BW-1:0] w_base;
`ifdef SEQ_ACC_PHASE_EN
   logic               relu_q, relu_d;
`else
   logic               w_unused_relu;
   assign w_unused_relu = cfg_relu;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      w_base_d = w_base_q;
      x_base_d = x_base_q;
      p_base_d = p_base_q;
      n_x_d    = n_x_q;
`ifdef SEQ_ACC_PHASE_EN
      relu_d   = relu_q;
`endif
      inst_d   = c_IDLE_INST;
      w_lim    = '0;
      w_base   = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               w_base_d = cfg_w_base;
               x_base_d = cfg_x_base;
               p_base_d = cfg_p_base;
               n_x_d    = cfg_n_x;
`ifdef SEQ_ACC_PHASE_EN
               relu_d   = cfg_relu;
`endif
               cnt_d    = '0;
               state_d  = (cfg_n_x == '0) ? S_DONE : S_WSTREAM;
            end
         end
         S_WSTREAM: begin
            if (cnt_q == CW'(COL + 1)) begin
               state_d = S_WFLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WFLUSH: begin
            if (cnt_q == CW'(ROW + COL - 1)) begin
               state_d = S_XSTREAM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_XSTREAM: begin
            if (cnt_q == {1'b0, n_x_q} + CW'(1)) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == {1'b0, n_x_q}) begin
`ifdef SEQ_ACC_PHASE_EN
               state_d = S_ACC;
`else
               state_d = S_DONE;
`endif
               cnt_d   = '0;
            end
         end
`ifdef SEQ_ACC_PHASE_EN
         S_ACC: begin
            if (cnt_q == {1'b0, n_x_q}) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // inst is registered, so it is built from the state/index being entered.
      case (state_d)
         S_WSTREAM, S_XSTREAM: begin
            if (state_d == S_WSTREAM) begin
               w_lim  = CW'(COL);
               w_base = w_base_d;
            end else begin
               w_lim  = {1'b0, n_x_d};
               w_base = x_base_d;
            end
            if (cnt_d < w_lim) begin
               inst_d[19]           = 1'b0;
               inst_d[7 +: ADDR_BW] = w_base + cnt_d[ADDR_BW-1:0];
            end
            if (cnt_d >= CW'(1) && cnt_d <= w_lim)
               inst_d[2] = 1'b1;
            if (cnt_d >= CW'(2)) begin
               inst_d[3] = 1'b1;
               if (state_d == S_WSTREAM) inst_d[0] = 1'b1;
               else                      inst_d[1] = 1'b1;
            end
         end
         S_DRAIN: begin
            if (ofifo_valid) begin
               inst_d[6]             = 1'b1;
               inst_d[32]            = 1'b0;
               inst_d[31]            = 1'b0;
               inst_d[20 +: ADDR_BW] = p_base_d + cnt_d[ADDR_BW-1:0];
               cnt_d                 = cnt_d + CW'(1);
            end
         end
`ifdef SEQ_ACC_PHASE_EN
         S_ACC: begin
            if (cnt_d < {1'b0, n_x_d}) begin
               inst_d[32]            = 1'b0;
               inst_d[20 +: ADDR_BW] = p_base_d + cnt_d[ADDR_BW-1:0];
            end
            if (cnt_d >= CW'(1))
               inst_d[33] = 1'b1;
            inst_d[34] = relu_d;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         w_base_q <= '0;
         x_base_q <= '0;
         p_base_q <= '0;
         n_x_q    <= '0;
`ifdef SEQ_ACC_PHASE_EN
         relu_q   <= 1'b0;
`endif
         inst_q   <= c_IDLE_INST;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         w_base_q <= w_base_d;
         x_base_q <= x_base_d;
         p_base_q <= p_base_d;
         n_x_q    <= n_x_d;
`ifdef SEQ_ACC_PHASE_EN
         relu_q   <= relu_d;
`endif
         inst_q   <= inst_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
      end
   end

   assign inst = inst_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// tb_core_sequencer: randomized scoreboard bench for core_sequencer.
// Expected outputs come from a cycle-placement model of the stage rules.
module tb_core_sequencer;
   localparam int ROW       = 8;
   localparam int COL       = 8;
   localparam int ADDR_BW   = 11;
   localparam int AMASK     = (1 << ADDR_BW) - 1;
   localparam int MAXC      = 1024;
   localparam int VLD_FORCE = 600;
   localparam logic [34:0] c_IDLE_INST = 35'h1_800C_0000;
`ifdef SEQ_ACC_PHASE_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [34:0] inst;
      logic        busy;
      logic        done;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [ADDR_BW-1:0] cfg_w_base = '0, cfg_x_base = '0, cfg_p_base = '0, cfg_n_x = '0;
   logic               cfg_relu = 1'b0;
   logic               ofifo_valid = 1'b0;
   logic [34:0]        inst;
   logic               busy, done;

   exp_t  q[$];
   exp_t  tr[MAXC];
   exp_t  mon_e;
   bit    vld[MAXC];
   int    tr_len, tr_last;
   int    n_cmp = 0;
   int    n_err = 0;
   string tag = "none";

   always #5 clk = ~clk;

   core_sequencer #(.ROW(ROW), .COL(COL), .ADDR_BW(ADDR_BW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_p_base(cfg_p_base),
      .cfg_n_x(cfg_n_x), .cfg_relu(cfg_relu), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done)
   );

   function automatic bit vld_at(input int c);
      return (c >= VLD_FORCE) ? 1'b1 : vld[c];
   endfunction

   // Places every event of one command on its absolute cycle (cycle 1 = first after accept).
   task automatic build_model(input int wb, input int xb, input int pb, input int nx, input bit relu);
      int x0, c, k;
      for (int i = 0; i < MAXC; i++) tr[i] = '{inst: c_IDLE_INST, busy: 1'b0, done: 1'b0};
      if (nx == 0) begin
         tr_last = 1;
      end else begin
         for (int j = 0; j < COL; j++) begin
            tr[1 + j].inst[19]    = 1'b0;
            tr[1 + j].inst[17:7]  = 11'((wb + j) & AMASK);
            tr[2 + j].inst[2]     = 1'b1;
            tr[3 + j].inst[3]     = 1'b1;
            tr[3 + j].inst[0]     = 1'b1;
         end
         x0 = 1 + (COL + 2) + (ROW + COL);
         for (int j = 0; j < nx; j++) begin
            tr[x0 + j].inst[19]    = 1'b0;
            tr[x0 + j].inst[17:7]  = 11'((xb + j) & AMASK);
            tr[x0 + 1 + j].inst[2] = 1'b1;
            tr[x0 + 2 + j].inst[3] = 1'b1;
            tr[x0 + 2 + j].inst[1] = 1'b1;
         end
         c = x0 + nx + 2;
         k = 0;
         while (k < nx) begin
            if (vld_at(c - 1)) begin
               tr[c].inst[6]     = 1'b1;
               tr[c].inst[32]    = 1'b0;
               tr[c].inst[31]    = 1'b0;
               tr[c].inst[30:20] = 11'((pb + k) & AMASK);
               k++;
            end
            c++;
         end
         if (ACC_EN) begin
            for (int i = 0; i <= nx; i++) begin
               if (i < nx) begin
                  tr[c + i].inst[32]    = 1'b0;
                  tr[c + i].inst[30:20] = 11'((pb + i) & AMASK);
               end
               if (i >= 1) tr[c + i].inst[33] = 1'b1;
               tr[c + i].inst[34] = relu;
            end
            c = c + nx + 1;
         end
         tr_last = c;
      end
      for (int i = 1; i <= tr_last; i++) tr[i].busy = 1'b1;
      tr[tr_last].done = 1'b1;
      tr_len = tr_last + 2;
   endtask

   // Entered and left at #1 after a rising edge with the DUT idle.
   // vmode: 0 random valid, 1 valid held high, 2 stall pattern in DRAIN.
   task automatic run(input string name, input int wb, input int xb, input int pb, input int nx,
                      input bit relu, input int vmode, input int rst_cyc, input int start_cyc_in);
      bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int d0, n_push, start_cyc;
      tag = name;
      for (int i = 0; i < MAXC; i++) vld[i] = (vmode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
      if (vmode == 2) begin
         d0 = 1 + (COL + 2) + (ROW + COL) + nx + 2;
         for (int m = 0; m < 7; m++) vld[d0 - 1 + m] = pat[m];
      end
      build_model(wb, xb, pb, nx, relu);
      start_cyc = start_cyc_in;
      if (start_cyc == -2) start_cyc = (tr_last > 1) ? int'($urandom_range(tr_last - 1, 1)) : -1;
      start       = 1'b1;
      cfg_w_base  = 11'(wb);
      cfg_x_base  = 11'(xb);
      cfg_p_base  = 11'(pb);
      cfg_n_x     = 11'(nx);
      cfg_relu    = relu;
      ofifo_valid = vld_at(0);
      n_push = (rst_cyc >= 0) ? rst_cyc + 1 : tr_len;
      for (int i = 0; i < n_push; i++) q.push_back(tr[i]);
      for (int c = 1; c < n_push; c++) begin
         @(posedge clk); #1;
         start       = (c == start_cyc);
         cfg_w_base  = 11'($urandom);
         cfg_x_base  = 11'($urandom);
         cfg_p_base  = 11'($urandom);
         cfg_n_x     = 11'($urandom_range(60, 0));
         cfg_relu    = 1'($urandom);
         ofifo_valid = vld_at(c);
         if (c == rst_cyc) reset = 1'b1;
      end
      @(posedge clk); #1;
      if (rst_cyc >= 0) begin
         reset = 1'b0;
         q.push_back('{inst: c_IDLE_INST, busy: 1'b0, done: 1'b0});
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      tag = "reset";
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         q.push_back('{inst: c_IDLE_INST, busy: 1'b0, done: 1'b0});
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         n_cmp++;
         if ({inst, busy, done} !== {mon_e.inst, mon_e.busy, mon_e.done}) begin
            n_err++;
            $display("FAIL %s t=%0t: got inst=%h busy=%b done=%b, want inst=%h busy=%b done=%b",
                     tag, $time, inst, busy, done, mon_e.inst, mon_e.busy, mon_e.done);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      do_reset();
      run("full",      10,   200,  100,  4, 1'b0, 1, -1, -1);
      run("stall",     30,    40,  500,  4, 1'b0, 2, -1, -1);
      run("xwrap",      5,  2046,    7,  4, 1'b0, 0, -1, -1);
      run("nx0",        1,     2,    3,  0, 1'b1, 1, -1, -1);
      run("start_ign", 12,   300,  900,  5, 1'b0, 1, -1, 28);
      run("acc_relu",   0,    50, 2046,  3, 1'b1, 1, -1, -1);
      run("mid_rst",    8,    16,   32,  4, 1'b0, 1, 29, -1);
      run("after_rst", 2040,  60,  700,  6, 1'b1, 0, -1, -1);
      do_reset();
      for (int r = 0; r < 10; r++)
         run("random", int'($urandom_range(AMASK, 0)), int'($urandom_range(AMASK, 0)),
             int'($urandom_range(AMASK, 0)), int'($urandom_range(40, 1)), 1'($urandom),
             0, -1, -2);
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Layer-level instruction sequencer for the core datapath. Given one start command, it generates the 35-bit `inst` word every cycle and walks the core through four stages: weight streaming from activation/weight SRAM into L0 and the array, array flush, activation streaming with execute, and output-FIFO drain into psum SRAM. It sits directly above `core` and replaces the testbench-driven instruction stream.

## Interface
- `row`, 8: PE array rows; used for the flush length.
- `col`, 8: PE array columns; sets the weight-word count and flush length.
- `addr_bw`, 11: SRAM address width for both memories.
- `clk`  in  1  clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `cfg_w_base`  in  addr_bw  xmem address of the first weight word.
- `cfg_x_base`  in  addr_bw  xmem address of the first activation word.
- `cfg_p_base`  in  addr_bw  pmem address of the first output word.
- `cfg_n_x`  in  addr_bw  number of activation vectors; legal range 0..2047.
- `cfg_relu`  in  1  ReLU enable for the accumulate pass.
- `ofifo_valid`  in  1  from `core`; an output word is available.
- `inst`  out  35  instruction word to `core`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- `inst` field map:
  - [0] kernel load.
  - [1] execute.
  - [2] l0_wr.
  - [3] l0_rd.
  - [5:4] always 0.
  - [6] ofifo_rd.
  - [17:7] xmem A.
  - [18] xmem WEN, active low.
  - [19] xmem CEN, active low.
  - [30:20] pmem A.
  - [31] pmem WEN, active low.
  - [32] pmem CEN, active low.
  - [33] accumulate.
  - [34] relu.
- "Idle inst": bits 19, 18, 32 and 31 are 1; all other bits are 0. Any field not driven in a state takes its idle value.
- The xmem interface never writes: WEN stays 1 at all times.
- Start acceptance:
  - `start` is accepted only in IDLE.
  - On the accepting edge, all `cfg_*` inputs are latched. Later changes to `cfg_*` have no effect until the next accepted start.
  - `start` in any other state is ignored.
- States:
  - IDLE: wait for `start`. If the latched `cfg_n_x` is 0, go to DONE and issue no memory operations. Otherwise go to WSTREAM.
  - WSTREAM (col+2 cycles), cycle index j from 0:
    - For j<col: xmem read (CEN=0) at `w_base+j`.
    - For 1≤j≤col: l0_wr=1.
    - For 2≤j≤col+1: l0_rd=1 and inst[0]=1.
  - WFLUSH (row+col cycles): idle inst.
  - XSTREAM (n_x+2 cycles): same three-stage pipeline as WSTREAM, with reads at `x_base+j` for j<n_x and inst[1]=1 in place of inst[0].
  - DRAIN:
    - Each cycle `ofifo_valid`=1: assert ofifo_rd=1 and a pmem write (CEN=0, WEN=0) at `p_base+k` in the same cycle, then k++.
    - `ofifo_valid`=0 stalls the stage with idle inst.
    - Exit when k=n_x.
  - ACC (only with the macro enabled, see Configuration).
  - DONE (1 cycle): `done`=1 with idle inst, then return to IDLE.
- Address arithmetic is modulo 2^addr_bw; base+index wraps, e.g. 2047+1 → 0.
- Reset in any state, including mid-operation: next state is IDLE, `inst` = idle inst, `busy`=0, `done`=0, all counters cleared. No pending write is completed.

## Timing
- Cycle 0 is the edge on which `start` is accepted. `busy` is 1 from cycle 1.
- WSTREAM occupies cycles 1..col+2, WFLUSH the next row+col cycles, and XSTREAM the next n_x+2 cycles.
- Example with row=col=8, n_x=4:
  - WSTREAM cycles 1–10.
  - WFLUSH cycles 11–26.
  - XSTREAM cycles 27–32: reads 27–30, l0_wr 28–31, exec 29–32.
  - DRAIN from cycle 33.
- SRAM read latency is 1 cycle. l0_wr is therefore always asserted one cycle after its xmem read, and l0_rd one cycle after the corresponding l0_wr.
- `done` is asserted in the cycle after the final DRAIN or ACC operation. `busy` falls in the same cycle that `done` falls.
- `inst` is a registered output; nothing from input to output is combinational.

## Configuration
- `SEQ_ACC_PHASE_EN` defined:
  - DRAIN goes to ACC.
  - ACC runs n_x+1 cycles, cycle index i from 0:
    - For i<n_x: pmem read (CEN=0, WEN=1) at `p_base+i`.
    - For 1≤i≤n_x: inst[33]=1.
    - For all i: inst[34] = latched `cfg_relu`.
  - ACC then goes to DONE.
- `SEQ_ACC_PHASE_EN` not defined:
  - DRAIN goes directly to DONE.
  - inst[33] and inst[34] are constant 0.
  - `cfg_relu` is ignored.

## Test plan
- Reset check: hold `reset` high for 3 cycles → `inst`=0x1_800C_0000 (bits 32, 31, 19, 18 set), `busy`=0, `done`=0. Repeat after a run.
- Full run, row=col=8, n_x=4, p_base=100, `ofifo_valid` held 1, macro off:
  - WSTREAM and XSTREAM pulses land on the cycles in the Timing example.
  - pmem writes to 100–103 occur at cycles 33–36.
  - `done` pulses at cycle 37.
- DRAIN stall: drive `ofifo_valid` with pattern 1,0,0,1,1,0,1 → exactly 4 writes, each coincident with ofifo_rd, and `done` one cycle after the 4th write.
- Boundary cases:
  - x_base=2046, n_x=4 → xmem reads at 2046, 2047, 0, 1.
  - n_x=0 → `done` at cycle 1 with no CEN=0 cycles.
  - `start` pulsed during XSTREAM → ignored, and a changed `cfg_n_x` has no effect on the run.
- Reset mid-operation: assert `reset` during XSTREAM cycle 29 → next cycle `inst` is idle and the state is IDLE. A following start runs a complete, correct sequence.
- `SEQ_ACC_PHASE_EN` defined, n_x=3, `cfg_relu`=1: after DRAIN, pmem reads at p_base..p_base+2 on consecutive cycles, inst[33]=1 on the 3 following cycles, inst[34]=1 throughout ACC, and `done` pulses next.
